// File: rtl/exec_sequencer_if.sv
// Issue/complete handshake between the instruction sequencer and the matrix datapath.
// The sequencer is the master: it presents an op and its operands, and the datapath accepts it and later reports completion.
interface exec_sequencer_if #(
   parameter int REG_W = 3
);
   logic             issue_valid;
   logic             issue_ready;
   logic [7:0]       issue_sel;
   logic [REG_W-1:0] issue_dest;
   logic [REG_W-1:0] issue_src1;
   logic [REG_W-1:0] issue_src2;
   logic             unit_done;

   modport master (
      output issue_valid, issue_sel, issue_dest, issue_src1, issue_src2,
      input  issue_ready, unit_done
   );

   modport slave (
      input  issue_valid, issue_sel, issue_dest, issue_src1, issue_src2,
      output issue_ready, unit_done
   );
endinterface

// File: rtl/exec_sequencer.sv
// Instruction sequencer: fetches from a synchronous program memory, decodes, and issues ops to the matrix datapath.
// It then waits for the op to complete, and traps hung units (timeout) and runs past the end of memory (PC overrun).
module exec_sequencer #(
   parameter int REG_W  = 3,
   parameter int ADDR_W = 6,
   parameter int TMO_W  = 8,
   parameter int CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic [ADDR_W-1:0]      prog_addr,
   output logic                   prog_rd,
   input  logic [3+3*REG_W-1:0]   inst_data,
   exec_sequencer_if.master       bus,
   output logic                   busy,
   output logic                   halted,
   output logic [1:0]             err_code,
   output logic [CNT_W-1:0]       retired
);

   localparam int INST_W = 3 + 3*REG_W;
   localparam logic [TMO_W-1:0] TMO_LAST = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_HALT, S_ERROR
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP, OP_LOAD, OP_ADD, OP_SUB, OP_SMUL, OP_MMUL, OP_TRANS, OP_STOP
   } opcode_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [TMO_W-1:0]  tmo_cnt;
   opcode_t           opcode;
   logic              pc_last;

   assign opcode    = opcode_t'(inst_data[INST_W-1 -: 3]);
   assign pc_last   = (pc == '1);
   assign prog_addr = pc;
   assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                      (state == S_ISSUE) || (state == S_WAIT);
   assign halted    = (state == S_HALT);

   // Advancing past the last program address traps with err_code 10 and leaves the PC on that address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= S_IDLE;
         pc              <= '0;
         tmo_cnt         <= '0;
         retired         <= '0;
         err_code        <= 2'b00;
         prog_rd         <= 1'b0;
         bus.issue_valid <= 1'b0;
         bus.issue_sel   <= 8'h00;
         bus.issue_dest  <= '0;
         bus.issue_src1  <= '0;
         bus.issue_src2  <= '0;
      end else begin
         case (state)
            S_IDLE, S_HALT, S_ERROR: begin
               if (start) begin
                  state    <= S_FETCH;
                  pc       <= '0;
                  retired  <= '0;
                  err_code <= 2'b00;
                  prog_rd  <= 1'b1;
               end
            end
            S_FETCH: begin
               prog_rd <= 1'b0;
               state   <= S_DECODE;
            end
            S_DECODE: begin
               if (opcode == OP_NOP) begin
                  if (pc_last) begin
                     state    <= S_ERROR;
                     err_code <= 2'b10;
                  end else begin
                     pc      <= pc + ADDR_W'(1);
                     prog_rd <= 1'b1;
                     state   <= S_FETCH;
                  end
               end else if (opcode == OP_STOP) begin
                  state <= S_HALT;
               end else begin
                  bus.issue_valid <= 1'b1;
                  bus.issue_sel   <= 8'h01 << opcode;
                  bus.issue_dest  <= inst_data[3*REG_W-1 -: REG_W];
                  bus.issue_src1  <= inst_data[2*REG_W-1 -: REG_W];
                  bus.issue_src2  <= inst_data[REG_W-1:0];
                  state           <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (bus.issue_ready) begin
                  bus.issue_valid <= 1'b0;
                  bus.issue_sel   <= 8'h00;
                  bus.issue_dest  <= '0;
                  bus.issue_src1  <= '0;
                  bus.issue_src2  <= '0;
                  tmo_cnt         <= '0;
                  state           <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.unit_done) begin
                  if (retired != '1) retired <= retired + CNT_W'(1);
                  if (pc_last) begin
                     state    <= S_ERROR;
                     err_code <= 2'b10;
                  end else begin
                     pc      <= pc + ADDR_W'(1);
                     prog_rd <= 1'b1;
                     state   <= S_FETCH;
                  end
               end else if (tmo_cnt + TMO_W'(1) == TMO_LAST) begin
                  state    <= S_ERROR;
                  err_code <= 2'b01;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
